// File: rtl/memory_param.sv
// memory_param: simple dual-port RAM with byte enables, selectable
// read-during-write behaviour, optional output register and a
// self-sequenced clear of the whole array (run after reset or on request).
module memory_param #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned RDW_MODE = 0,
  parameter int unsigned OUT_REG  = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  input  logic                clr_req,
  output logic                busy
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {CLEAR, IDLE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                wr_acc;
  logic                rd_acc;
  logic [DATA_W-1:0]   wr_merged;
  logic [DATA_W-1:0]   rd_word;

  logic                rd_valid_q;
  logic [DATA_W-1:0]   rd_data_q;

  // State register: reset always (re)starts a clear from address 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: CLEAR walks every address once, terminal compare ends it
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = IDLE;
      end
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // Outputs / request qualification: all requests are dropped while clearing
  always_comb begin
    busy   = (state_q == CLEAR);
    wr_acc = wr_en && (state_q == IDLE);
    rd_acc = rd_en && (state_q == IDLE);
  end

  // Byte-merged write word and read word with read-during-write selection
  always_comb begin
    wr_merged = mem_q[wr_addr];
    for (int unsigned b = 0; b < NB; b++) begin
      if (wr_be[b]) wr_merged[b*8 +: 8] = wr_data[b*8 +: 8];
    end
    rd_word = mem_q[rd_addr];
    if ((RDW_MODE != 0) && wr_acc && (wr_addr == rd_addr)) rd_word = wr_merged;
  end

  // Array write port: clear zeroes one word per cycle, otherwise user writes
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR)  mem_q[cnt_q]   <= '0;
      else if (wr_acc)       mem_q[wr_addr] <= wr_merged;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic              s1_valid_q;
      logic [DATA_W-1:0] s1_data_q;

      // Two-stage read pipeline; stage 2 keeps draining while clearing
      always_ff @(posedge clk) begin
        if (rst) begin
          s1_valid_q <= 1'b0;
          s1_data_q  <= '0;
          rd_valid_q <= 1'b0;
          rd_data_q  <= '0;
        end else begin
          s1_valid_q <= rd_acc;
          if (rd_acc) s1_data_q <= rd_word;
          rd_valid_q <= s1_valid_q;
          if (s1_valid_q) rd_data_q <= s1_data_q;
        end
      end
    end else begin : g_noreg
      // Single-stage read: data register holds until the next completed read
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_valid_q <= 1'b0;
          rd_data_q  <= '0;
        end else begin
          rd_valid_q <= rd_acc;
          if (rd_acc) rd_data_q <= rd_word;
        end
      end
    end
  endgenerate

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_memory_param.sv
// Bench for memory_param: four instances (RDW_MODE x OUT_REG) share one
// stimulus stream; a word-array reference model predicts every output.
module tb_memory_param;

  logic        clk = 1'b0;
  logic        rst, wr_en, rd_en, clr_req;
  logic [3:0]  wr_addr, rd_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;

  logic [15:0] rdd [4];
  logic        rdv [4];
  logic        bsy [4];

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [15:0] mdl [16];
  int          clr_left = 16;
  bit          ev [4];
  logic [15:0] ed [4];
  bit          pacc;
  logic [15:0] pdat [2];
  int          edge_n = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    memory_param #(.DATA_W(16), .ADDR_W(4), .RDW_MODE(g % 2), .OUT_REG(g / 2)) u_dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd[g]),
      .rd_valid(rdv[g]), .clr_req(clr_req), .busy(bsy[g]));
  end

  // Drive one cycle of inputs, advance the model across the edge, sample #1 later
  task automatic step(input bit r, input bit we, input logic [3:0] wa, input logic [15:0] wd,
                      input logic [1:0] be, input bit re, input logic [3:0] ra, input bit cr);
    logic [15:0] merged;
    logic [15:0] cur [2];
    bit          idle, acc;
    @(negedge clk);
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    rd_en = re; rd_addr = ra; clr_req = cr;
    @(posedge clk);
    edge_n++;
    if (r) begin
      clr_left = 16;
      pacc = 0;
      for (int i = 0; i < 4; i++) begin ev[i] = 0; ed[i] = 16'h0; end
    end else begin
      idle = (clr_left == 0);
      acc  = idle && re;
      merged = mdl[wa];
      if (be[0]) merged[7:0]  = wd[7:0];
      if (be[1]) merged[15:8] = wd[15:8];
      cur[0] = mdl[ra];
      cur[1] = (idle && we && wa == ra) ? merged : mdl[ra];
      for (int i = 0; i < 4; i++) begin
        if (i / 2 == 0) begin
          ev[i] = acc;
          if (acc) ed[i] = cur[i % 2];
        end else begin
          ev[i] = pacc;
          if (pacc) ed[i] = pdat[i % 2];
        end
      end
      pacc = acc;
      pdat = cur;
      if (!idle) begin
        mdl[16 - clr_left] = 16'h0;
        clr_left--;
      end else begin
        if (we) mdl[wa] = merged;
        if (cr) clr_left = 16;
      end
    end
    #1;
  endtask

  task automatic idle_step();
    step(0, 0, 4'h0, 16'h0, 2'b00, 0, 4'h0, 0);
  endtask

  task automatic test_reset();
    int n;
    int pulses [4];
    step(1, 0, 4'h0, 16'h0, 2'b00, 0, 4'h0, 0);
    step(1, 1, 4'h2, 16'hFFFF, 2'b11, 1, 4'h2, 1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rdv[i] !== 1'b0 || rdd[i] !== 16'h0 || bsy[i] !== 1'b1) begin
        errors++;
        $display("FAIL reset_state inst=%0d valid=%b data=%h busy=%b required 0/0000/1", i, rdv[i], rdd[i], bsy[i]);
      end
    end
    n = 0;
    while (bsy[0] === 1'b1 && n < 40) begin
      n++;
      idle_step();
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rdv[i] !== ev[i] || rdd[i] !== ed[i] || bsy[i] !== (clr_left > 0)) begin
          errors++;
          $display("FAIL reset_clear inst=%0d valid=%b/%b data=%h/%h busy=%b", i, rdv[i], ev[i], rdd[i], ed[i], bsy[i]);
        end
      end
    end
    checks++;
    if (n !== 16) begin errors++; $display("FAIL reset_busy_len got=%0d required=16", n); end
    for (int i = 0; i < 4; i++) pulses[i] = 0;
    for (int a = 0; a < 18; a++) begin
      if (a < 16) step(0, 0, 4'h0, 16'h0, 2'b00, 1, a[3:0], 0);
      else idle_step();
      for (int i = 0; i < 4; i++) begin
        if (rdv[i] === 1'b1) pulses[i]++;
        checks++;
        if (rdv[i] !== ev[i] || rdd[i] !== 16'h0) begin
          errors++;
          $display("FAIL reset_readback inst=%0d valid=%b/%b data=%h required 0000", i, rdv[i], ev[i], rdd[i]);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (pulses[i] !== 16) begin errors++; $display("FAIL reset_pulses inst=%0d got=%0d required=16", i, pulses[i]); end
    end
  endtask

  task automatic test_byte_en();
    logic [15:0] seen [4];
    step(0, 1, 4'h3, 16'hABCD, 2'b11, 0, 4'h0, 0);
    step(0, 1, 4'h3, 16'h12EE, 2'b10, 0, 4'h0, 0);
    step(0, 0, 4'h0, 16'h0, 2'b00, 1, 4'h3, 0);
    for (int i = 0; i < 4; i++) seen[i] = 16'hDEAD;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) if (rdv[i] === 1'b1) seen[i] = rdd[i];
      idle_step();
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (seen[i] !== 16'h12CD) begin errors++; $display("FAIL byte_en inst=%0d got=%h required=12CD", i, seen[i]); end
    end
  endtask

  task automatic test_rdw();
    logic [15:0] seen [4];
    logic [15:0] req;
    step(0, 1, 4'h5, 16'h1111, 2'b11, 0, 4'h0, 0);
    step(0, 1, 4'h5, 16'h2222, 2'b11, 1, 4'h5, 0);
    for (int i = 0; i < 4; i++) seen[i] = 16'hDEAD;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) if (rdv[i] === 1'b1) seen[i] = rdd[i];
      idle_step();
    end
    for (int i = 0; i < 4; i++) begin
      req = (i % 2 == 1) ? 16'h2222 : 16'h1111;
      checks++;
      if (seen[i] !== req) begin errors++; $display("FAIL rdw inst=%0d got=%h required=%h", i, seen[i], req); end
    end
    step(0, 0, 4'h0, 16'h0, 2'b00, 1, 4'h5, 0);
    for (int i = 0; i < 4; i++) seen[i] = 16'hDEAD;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) if (rdv[i] === 1'b1) seen[i] = rdd[i];
      idle_step();
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (seen[i] !== 16'h2222) begin errors++; $display("FAIL rdw_after inst=%0d got=%h required=2222", i, seen[i]); end
    end
  endtask

  task automatic test_latency();
    int acc_edge, first [4], last [4], cnt [4];
    for (int i = 0; i < 4; i++) begin first[i] = -1; last[i] = -1; cnt[i] = 0; end
    acc_edge = edge_n + 1;
    for (int k = 0; k < 7; k++) begin
      if (k < 4) step(0, 0, 4'h0, 16'h0, 2'b00, 1, k[3:0], 0);
      else idle_step();
      for (int i = 0; i < 4; i++) begin
        if (rdv[i] === 1'b1) begin
          cnt[i]++;
          if (first[i] < 0) first[i] = edge_n;
          last[i] = edge_n;
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (first[i] - acc_edge + 1 !== 1 + i / 2) begin
        errors++;
        $display("FAIL latency inst=%0d got=%0d required=%0d", i, first[i] - acc_edge + 1, 1 + i / 2);
      end
      checks++;
      if (cnt[i] !== 4 || last[i] - first[i] !== 3) begin
        errors++;
        $display("FAIL back_to_back inst=%0d pulses=%0d span=%0d required 4/3", i, cnt[i], last[i] - first[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] wa, ra;
    for (int k = 0; k < 300; k++) begin
      wa = 4'($urandom_range(15));
      ra = ($urandom_range(3) == 0) ? wa : 4'($urandom_range(15));
      step(0, 1'($urandom), wa, 16'($urandom), 2'($urandom), 1'($urandom), ra,
           ($urandom_range(80) == 0));
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rdv[i] !== ev[i] || rdd[i] !== ed[i] || bsy[i] !== (clr_left > 0)) begin
          errors++;
          $display("FAIL random inst=%0d valid=%b/%b data=%h/%h busy=%b", i, rdv[i], ev[i], rdd[i], ed[i], bsy[i]);
        end
      end
    end
    while (clr_left > 0) idle_step();
  endtask

  task automatic test_clear();
    int n, stray;
    for (int a = 0; a < 16; a++) step(0, 1, a[3:0], 16'hFFFF, 2'b11, 0, 4'h0, 0);
    step(0, 0, 4'h0, 16'h0, 2'b00, 1, 4'h9, 1);
    n = 0; stray = 0;
    while (bsy[0] === 1'b1 && n < 40) begin
      n++;
      step(0, 1, 4'($urandom_range(15)), 16'hBEEF, 2'b11, 1, 4'($urandom_range(15)), 1);
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rdv[i] !== ev[i] || rdd[i] !== ed[i]) begin
          errors++;
          $display("FAIL clear_busy inst=%0d valid=%b/%b data=%h/%h", i, rdv[i], ev[i], rdd[i], ed[i]);
        end
        if (n > 1 && rdv[i] === 1'b1) stray++;
        if (n == 1 && i / 2 == 1 && rdd[i] !== 16'hFFFF) stray++;
      end
    end
    checks++;
    if (n !== 16 || stray !== 0) begin errors++; $display("FAIL clear_len busy=%0d stray=%0d required 16/0", n, stray); end
    for (int a = 0; a < 18; a++) begin
      if (a < 16) step(0, 0, 4'h0, 16'h0, 2'b00, 1, a[3:0], 0);
      else idle_step();
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rdv[i] !== ev[i] || (rdv[i] === 1'b1 && rdd[i] !== 16'h0)) begin
          errors++;
          $display("FAIL clear_readback inst=%0d valid=%b/%b data=%h required 0000", i, rdv[i], ev[i], rdd[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int n, stray;
    step(0, 1, 4'h7, 16'h5A5A, 2'b11, 0, 4'h0, 0);
    step(0, 0, 4'h0, 16'h0, 2'b00, 1, 4'h7, 0);
    step(1, 0, 4'h0, 16'h0, 2'b00, 0, 4'h0, 0);
    stray = 0;
    for (int i = 0; i < 4; i++) if (rdv[i] !== 1'b0 || rdd[i] !== 16'h0) stray++;
    while (clr_left > 0) idle_step();
    step(0, 0, 4'h0, 16'h0, 2'b00, 0, 4'h0, 1);
    for (int k = 0; k < 7; k++) step(0, 0, 4'h0, 16'h0, 2'b00, 1, 4'h1, 0);
    step(1, 0, 4'h0, 16'h0, 2'b00, 1, 4'h1, 0);
    n = 0;
    while (bsy[0] === 1'b1 && n < 40) begin
      n++;
      step(0, 1, 4'h1, 16'h7777, 2'b11, 1, 4'h1, 0);
      for (int i = 0; i < 4; i++) begin
        if (bsy[0] === 1'b1 && rdv[i] !== 1'b0) stray++;
        if (bsy[i] !== bsy[0]) stray++;
      end
    end
    checks++;
    if (n !== 16 || stray !== 0) begin errors++; $display("FAIL reset_mid_clear busy=%0d stray=%0d required 16/0", n, stray); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rdv[i] !== ev[i] || rdd[i] !== ed[i]) begin
        errors++;
        $display("FAIL reset_mid_end inst=%0d valid=%b/%b data=%h/%h", i, rdv[i], ev[i], rdd[i], ed[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_req = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
    for (int a = 0; a < 16; a++) mdl[a] = 16'hxxxx;
    test_reset();
    test_byte_en();
    test_rdw();
    test_latency();
    test_random();
    test_clear();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_param.md
MEMORY_PARAM -- requirements
Module: memory_param

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  DATA_W    16   data word width in bits; SHALL be a multiple of 8.
  ADDR_W    8    address width; depth = 2**ADDR_W words.
  RDW_MODE  0    same-address read-during-write: 0 = old data, 1 = new data.
  OUT_REG   0    0 = read latency 1 cycle; 1 = read latency 2 cycles, extra output register.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
  clk      input   1          rising-edge clock.
  rst      input   1          synchronous active-high reset.
  wr_en    input   1          write request.
  wr_addr  input   ADDR_W     write address.
  wr_data  input   DATA_W     write data.
  wr_be    input   DATA_W/8   byte enables; bit i covers wr_data[8i+7:8i].
  rd_en    input   1          read request.
  rd_addr  input   ADDR_W     read address.
  rd_data  output  DATA_W     registered read data.
  rd_valid output  1          one-cycle pulse; rd_data holds a fresh result.
  clr_req  input   1          request to zero the whole array.
  busy     output  1          clear sequence in progress; requests ignored.

Function
REQ-004 Independent read and write ports (simple dual-port); one write and one read accepted per cycle when busy=0.
REQ-005 Write: on rising edge with wr_en=1, busy=0, each byte of mem[wr_addr] with wr_be bit set SHALL take the matching byte of wr_data; unenabled bytes unchanged; wr_be=0 is a no-op.
REQ-006 Read: rd_en=1, busy=0 at edge N -> rd_data = mem[rd_addr] and rd_valid=1 after edge N+1 (OUT_REG=0) or N+2 (OUT_REG=1).
REQ-007 rd_valid SHALL be high exactly one cycle per accepted read; back-to-back reads give back-to-back pulses, no bubbles.
REQ-008 rd_data SHALL hold its last value when no read completes.
REQ-009 Same-address read and write in one cycle: RDW_MODE=0 returns pre-write word; RDW_MODE=1 returns post-write byte-merged word.
REQ-010 FSM states SHALL be CLEAR and IDLE.
REQ-011 CLEAR: a clear counter starting at 0 writes all-zero to mem[counter] each cycle, increments by 1; after writing address 2**ADDR_W-1 the next state is IDLE; clear lasts exactly 2**ADDR_W cycles.
REQ-012 IDLE -> CLEAR when clr_req=1 at an edge; counter reloads 0.
REQ-013 busy SHALL be 1 in CLEAR, 0 in IDLE.
REQ-014 In CLEAR, wr_en, rd_en and clr_req SHALL be ignored (no write, no rd_valid, no restart); requests are not queued.
REQ-015 Reads accepted before entering CLEAR SHALL complete normally with pre-clear data through the pipeline.
REQ-016 Counter SHALL wrap-free: width ADDR_W+1 or terminal-compare; no address written twice in one clear.

Reset
REQ-017 rst=1 at an edge SHALL set state CLEAR, counter 0, busy 1, rd_valid 0, rd_data 0, pipeline valid bits 0.
REQ-018 rst asserted mid-clear SHALL restart the clear from address 0.
REQ-019 rst asserted with reads in flight SHALL drop them; no rd_valid after reset.
REQ-020 Array contents SHALL be all zero after the post-reset clear completes; no reliance on simulation initial values.

Verification
REQ-021 Bench SHALL cover, at ADDR_W=4, DATA_W=16:
  - Reset release: rst 1 then 0 -> busy=1 for exactly 16 cycles then 0; read all 16 addresses -> 0x0000, one rd_valid each.
  - Byte enables: write 0xABCD to addr 3 with be=11, then 0x12xx with be=10 -> read addr 3 = 0x12CD.
  - Read-during-write addr 5 (old 0x1111, new 0x2222, be=11): RDW_MODE=0 -> 0x1111; RDW_MODE=1 -> 0x2222; next read 0x2222 both.
  - Latency: rd_en at cycle N, OUT_REG=0 -> rd_valid at N+1; OUT_REG=1 -> N+2; 4 consecutive reads -> 4 consecutive pulses.
  - clr_req after writing 0xFFFF to all addresses -> busy 16 cycles, wr_en/rd_en during busy ignored (no rd_valid), afterwards all reads 0x0000.
  - rst at clear cycle 7 -> busy stays 1 for 16 further cycles, rd_valid stays 0.
